glb_read_streamer: RTL

GLB_READ_STREAMER -- requirements
Module: glb_read_streamer

---
 rtl/glb_read_streamer_pkg.sv | 24 ++
 rtl/glb_read_streamer_if.sv | 18 +
 rtl/glb_read_streamer_valid_pipe.sv | 39 +++
 rtl/glb_read_streamer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/glb_read_streamer_pkg.sv
// Shared NoC package: router direction enum, GLB read streamer states and default widths.
package glb_read_streamer_pkg;

    localparam int unsigned GLB_DATA_WIDTH = 16;
    localparam int unsigned GLB_ADDR_WIDTH = 9;

    // Router port directions used across the NoC.
    typedef enum logic [2:0] {
        DIR_NORTH = 3'd0,
        DIR_SOUTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_WEST  = 3'd3,
        DIR_LOCAL = 3'd4
    } noc_dir_e;

    // GLB read streamer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/glb_read_streamer_if.sv
// GLB read port plus router west data/enable bundle driven by one streamer.
//   master (streamer): drives read_req, r_addr, data_o, enable_o; receives r_data
//   slave  (GLB/router side): the mirror image
interface glb_read_streamer_if
    import glb_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GLB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = GLB_ADDR_WIDTH
);
    logic                  read_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  enable_o;

    modport master (output read_req, r_addr, data_o, enable_o, input r_data);
    modport slave  (input read_req, r_addr, data_o, enable_o, output r_data);
endinterface

// File: rtl/glb_read_streamer_valid_pipe.sv
// Valid shift register tracking GLB reads in flight.
//   clk, reset : clock, async active-low reset
//   in_i       : a read is issued this cycle
//   tail_o     : GLB data for the oldest read is on r_data this cycle
//   any_o      : at least one read still in flight
module glb_rd_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic tail_o,
    output logic any_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Shift toward the tail; stage 0 takes the new read.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign tail_o = vld_q[DEPTH-1];
    assign any_o  = |vld_q;

endmodule

// File: rtl/glb_read_streamer.sv
// Streams length consecutive GLB words (wrapping address) into a router west input.
//   clk, reset       : clock, async active-low reset
//   start            : one-cycle transfer request, honoured only when idle
//   base_addr, length: first address and word count, sampled with start
//   stall            : holds off new reads; in-flight reads still deliver
//   busy, done       : not-idle flag, one-cycle completion pulse
//   bus              : GLB read port and router data/enable (master side)
module glb_read_streamer
    import glb_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GLB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = GLB_ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    glb_read_streamer_if.master   bus
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned CW = ADDR_WIDTH + 1;

    rd_state_e             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         last_addr_q;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  issue_c;
    logic                  tail_vld;
    logic                  pipe_any;

    glb_rd_valid_pipe #(.DEPTH(RD_LATENCY)) u_vpipe (
        .clk    (clk),
        .reset  (reset),
        .in_i   (issue_c),
        .tail_o (tail_vld),
        .any_o  (pipe_any)
    );

    // Next-state, address and count update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        issue_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = ST_ISSUE;
                        addr_d  = base_addr;
                        len_d   = length;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    issue_c = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // Empty pipe means the final word is already on enable_o.
            ST_DRAIN: begin
                if (!pipe_any) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            if (issue_c) begin
                last_addr_q <= addr_q;
            end
            if (tail_vld) begin
                data_q <= bus.r_data;
            end
            en_q   <= tail_vld;
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_q == ST_DONE);
        end
    end

    // Stall must gate the strobe in the same cycle, so the GLB strobe and
    // address are a decode of state; r_addr parks on the last issued address.
    assign bus.read_req = issue_c;
    assign bus.r_addr   = issue_c ? addr_q : last_addr_q;
    assign bus.data_o   = data_q;
    assign bus.enable_o = en_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
